lightshow_input_ctrl: RTL and testbench
=======================================

LIGHTSHOW_INPUT_CTRL -- requirements
Module: lightshow_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 1000000, the number of consecutive stable synchronized cycles required to accept a button change.
REQ-002 SHALL have parameter PERIOD_DEFAULT, default 50000000, the tick period in clocks after reset or enter.
REQ-003 SHALL have parameter PERIOD_MIN, default 5000000, the lowest allowed period.
REQ-004 SHALL have parameter PERIOD_MAX, default 100000000, the highest allowed period.
REQ-005 SHALL have parameter PERIOD_STEP, default 5000000, the period change per up/down press.
REQ-006 SHALL have port clk_100mhz  input  1  system clock; one clock domain only, all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have ports btn_up, btn_enter, btn_left, btn_down, btn_right  input  1 each  raw asynchronous buttons, pressed = high.
REQ-009 SHALL have port switch  input  8  raw asynchronous switches.
REQ-010 SHALL have port sw_sync  output  8  switches after a 2-flop synchronizer.
REQ-011 SHALL have port btn_level  output  5  debounced button states; bit order [0]=up [1]=enter [2]=left [3]=down [4]=right.
REQ-012 SHALL have port btn_pulse  output  5  one-cycle press strobes, same bit order as btn_level.
REQ-013 SHALL have port period  output  32  current tick period in clocks.
REQ-014 SHALL have port pattern_sel  output  2  selected light-show pattern.
REQ-015 SHALL have port tick  output  1  one-cycle strobe every period clocks.

Function
REQ-016 SHALL pass every button and switch through a 2-flop synchronizer before any other logic.
REQ-017 SHALL give each button its own debounce counter: it clears whenever the synchronized input equals btn_level, and increments otherwise.
REQ-018 SHALL toggle btn_level and clear the counter on the cycle the counter reaches DEBOUNCE_CNT-1 while the input still differs from btn_level.
REQ-019 SHALL restart that button's count from 0 on any bounce before acceptance, which resets the qualification window.
REQ-020 SHALL assert btn_pulse[i] for exactly one cycle, the same cycle btn_level[i] rises; a release generates no pulse.
REQ-021 SHALL update period on the cycle after a btn_pulse, as follows:
- enter pulse: load PERIOD_DEFAULT.
- up pulse alone: subtract PERIOD_STEP, saturating at PERIOD_MIN.
- down pulse alone: add PERIOD_STEP, saturating at PERIOD_MAX.
REQ-022 SHALL give enter priority over up and down when they pulse in the same cycle, and make no change when up and down pulse together without enter.
REQ-023 SHALL compute period arithmetic at 33 bits internally so it never wraps, clamping the result to [PERIOD_MIN, PERIOD_MAX].
REQ-024 SHALL increment pattern_sel modulo 4 on a right pulse (3 -> 0) and decrement it modulo 4 on a left pulse (0 -> 3), one cycle after the pulse.
REQ-025 SHALL make no change to pattern_sel when left and right pulse together.
REQ-026 SHALL run a tick counter from 0 to period-1, asserting tick for one cycle when count == period-1 and returning to 0 on that cycle.
REQ-027 SHALL reset the tick counter to 0 without a tick on any cycle in which period changes value; a press that leaves period unchanged because of saturation does not restart it.
REQ-028 SHALL be fully registered: every output comes directly from flops.

Reset
REQ-029 SHALL, while rst is high on a clock edge, clear the following:
- synchronizers, debounce counters, btn_level, btn_pulse, sw_sync, tick, tick counter and pattern_sel go to 0.
- period loads PERIOD_DEFAULT.
REQ-030 SHALL ignore button activity during reset; a button held through reset release is treated as a new press and debounced from zero, including when rst is asserted mid-operation or mid-debounce.

Verification (DEBOUNCE_CNT=4, PERIOD_DEFAULT=10, PERIOD_MIN=4, PERIOD_MAX=16, PERIOD_STEP=2)
REQ-031 SHALL verify: btn_up high continuously from cycle 0 -> btn_pulse[0] high for exactly one cycle, 2 sync + 4 debounce cycles after the input rises; period changes 10 -> 8 on the next cycle.
REQ-032 SHALL verify: btn_down toggled 1,0,1 every 2 cycles, then held -> no pulse until 4 consecutive stable cycles after the last edge, then exactly one pulse.
REQ-033 SHALL verify: five debounced down presses from reset -> period reads 12, 14, 16, 16, 16 (saturated); four further up presses -> 14, 12, 10, 8; then enter -> 10.
REQ-034 SHALL verify: left press from reset -> pattern_sel = 3; right pressed twice -> 0 then 1; left and right pulsing in the same cycle -> pattern_sel unchanged.
REQ-035 SHALL verify: with period = 10 -> tick pulses are exactly 10 cycles apart; an up press at count 6 -> counter restarts with no tick, the next tick comes 8 cycles after the change, then every 8 cycles.
REQ-036 SHALL verify: rst asserted for one cycle while btn_right is held mid-debounce with pattern_sel = 2 -> next cycle pattern_sel = 0, period = 10, all outputs 0; the held button produces one pulse after 2 sync + 4 debounce cycles.

Source files
------------

// File: rtl/lightshow_input_ctrl.sv
// Input conditioning and timing control for a light-show board.
// Buttons and switches are synchronized, buttons are debounced into levels
// and press strobes, and the presses adjust a tick period and a pattern index.
module lightshow_input_ctrl #(
  parameter int unsigned DEBOUNCE_CNT   = 1000000,
  parameter int unsigned PERIOD_DEFAULT = 50000000,
  parameter int unsigned PERIOD_MIN     = 5000000,
  parameter int unsigned PERIOD_MAX     = 100000000,
  parameter int unsigned PERIOD_STEP    = 5000000
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_enter,
  input  logic        btn_left,
  input  logic        btn_down,
  input  logic        btn_right,
  input  logic [7:0]  switch,
  output logic [7:0]  sw_sync,
  output logic [4:0]  btn_level,
  output logic [4:0]  btn_pulse,
  output logic [31:0] period,
  output logic [1:0]  pattern_sel,
  output logic        tick
);

  localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [32:0] MIN_PLUS_STEP = 33'(PERIOD_MIN) + 33'(PERIOD_STEP);

  // Button index map shared by btn_level / btn_pulse.
  localparam int B_UP = 0, B_ENTER = 1, B_LEFT = 2, B_DOWN = 3, B_RIGHT = 4;

  logic [4:0]       btn_raw;
  logic [4:0]       btn_meta, btn_sync;
  logic [7:0]       sw_meta;
  logic [CNT_W-1:0] db_cnt [5];
  logic [31:0]      period_next;
  logic [32:0]      period_sum;
  logic             period_change;
  logic [31:0]      tick_cnt;

  assign btn_raw = {btn_right, btn_down, btn_left, btn_enter, btn_up};

  // Two-flop synchronizers for every asynchronous input.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      sw_meta  <= switch;
      sw_sync  <= sw_meta;
    end
  end

  // Per-button debounce: count stable differing cycles, toggle the level on the last one.
  // NOTE: the counter array is a handful of flops, not a RAM, so resetting it in a loop is fine.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      btn_level <= '0;
      btn_pulse <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        btn_pulse[i] <= 1'b0;
        if (btn_sync[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_cnt[i]    <= '0;
          btn_level[i] <= btn_sync[i];
          btn_pulse[i] <= btn_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Next period from this cycle's strobes; widened sums keep the clamps wrap-free.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    period_next = period;
    period_sum  = {1'b0, period} + 33'(PERIOD_STEP);
    if (btn_pulse[B_ENTER]) begin
      period_next = 32'(PERIOD_DEFAULT);
    end else if (btn_pulse[B_UP] && !btn_pulse[B_DOWN]) begin
      if ({1'b0, period} < MIN_PLUS_STEP) period_next = 32'(PERIOD_MIN);
      else                                period_next = period - 32'(PERIOD_STEP);
    end else if (btn_pulse[B_DOWN] && !btn_pulse[B_UP]) begin
      if (period_sum > 33'(PERIOD_MAX)) period_next = 32'(PERIOD_MAX);
      else                              period_next = period_sum[31:0];
    end
    period_change = (period_next != period);
  end

  // Period register.
  always_ff @(posedge clk_100mhz) begin
    if (rst) period <= 32'(PERIOD_DEFAULT);
    else     period <= period_next;
  end

  // Pattern index: right steps forward, left steps back, both together cancel.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      pattern_sel <= '0;
    end else if (btn_pulse[B_RIGHT] && !btn_pulse[B_LEFT]) begin
      pattern_sel <= pattern_sel + 2'd1;
    end else if (btn_pulse[B_LEFT] && !btn_pulse[B_RIGHT]) begin
      pattern_sel <= pattern_sel - 2'd1;
    end
  end

  // Tick generator; a real period change restarts the count without a tick.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (period_change) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (tick_cnt == period - 32'd1) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
      tick     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lightshow_input_ctrl.sv
// Scoreboard bench for lightshow_input_ctrl with small timing parameters.
// Stimulus pushes expected press strobes and ticks; monitors pop and compare.
module tb_lightshow_input_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0, btn_enter = 1'b0, btn_left = 1'b0;
  logic        btn_down = 1'b0, btn_right = 1'b0;
  logic [7:0]  switch = 8'h00;
  logic [7:0]  sw_sync;
  logic [4:0]  btn_level, btn_pulse;
  logic [31:0] period;
  logic [1:0]  pattern_sel;
  logic        tick;

  lightshow_input_ctrl #(
    .DEBOUNCE_CNT(4), .PERIOD_DEFAULT(10), .PERIOD_MIN(4),
    .PERIOD_MAX(16), .PERIOD_STEP(2)
  ) dut (
    .clk_100mhz(clk), .rst(rst),
    .btn_up(btn_up), .btn_enter(btn_enter), .btn_left(btn_left),
    .btn_down(btn_down), .btn_right(btn_right),
    .switch(switch), .sw_sync(sw_sync), .btn_level(btn_level),
    .btn_pulse(btn_pulse), .period(period), .pattern_sel(pattern_sel),
    .tick(tick)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge k (and #1) cyc reads k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  pulse;
    logic [31:0] period;
    logic [1:0]  pattern;
  } pulse_exp_t;

  pulse_exp_t pq[$];
  int         tq[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         tick_en  = 1'b0;

  localparam logic [4:0] M_UP = 5'b00001, M_ENTER = 5'b00010, M_LEFT = 5'b00100;
  localparam logic [4:0] M_DOWN = 5'b01000, M_RIGHT = 5'b10000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_btns(input logic [4:0] m);
    btn_up = m[0]; btn_enter = m[1]; btn_left = m[2]; btn_down = m[3]; btn_right = m[4];
  endtask

  task automatic push_pulse(input int c, input logic [4:0] m, input logic [31:0] p,
                            input logic [1:0] s);
    pulse_exp_t e;
    e.cyc = c; e.pulse = m; e.period = p; e.pattern = s;
    pq.push_back(e);
  endtask

  // One rst edge; returns with cyc equal to the reset edge.
  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // Clean press: strobe expected 2 sync + 4 debounce edges after the input rises.
  task automatic press(input logic [4:0] m, input logic [31:0] p, input logic [1:0] s);
    set_btns(m);
    push_pulse(cyc + 6, m, p, s);
    step(8);
    set_btns(5'b0);
    step(10);
  endtask

  // Pulse monitor: compares each strobe, then period/pattern on the following cycle.
  pulse_exp_t cur;
  bit         pend = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        check("period_after_pulse", period, cur.period);
        check("pattern_after_pulse", 32'(pattern_sel), 32'(cur.pattern));
        pend = 1'b0;
      end
      if (btn_pulse != 5'b0) begin
        if (pq.size() == 0) begin
          check("unexpected_pulse", 32'(btn_pulse), 32'd0);
        end else begin
          cur = pq.pop_front();
          check("pulse_cycle", 32'(cyc), 32'(cur.cyc));
          check("pulse_value", 32'(btn_pulse), 32'(cur.pulse));
          pend = 1'b1;
        end
      end
    end
  end

  // Tick monitor: inside a window every tick must match the next expected cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (tick_en && tick) begin
        if (tq.size() == 0) check("unexpected_tick", 32'(tick), 32'd0);
        else                check("tick_cycle", 32'(cyc), 32'(tq.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int t0;
  initial begin
    // Reset state.
    step(2);
    check("rst_sw_sync", 32'(sw_sync), 32'd0);
    check("rst_btn_level", 32'(btn_level), 32'd0);
    check("rst_btn_pulse", 32'(btn_pulse), 32'd0);
    check("rst_period", period, 32'd10);
    check("rst_pattern", 32'(pattern_sel), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);

    // Up held from the first cycle out of reset: 10 -> 8.
    rst = 1'b0;
    btn_up = 1'b1;
    push_pulse(cyc + 6, M_UP, 32'd8, 2'd0);
    step(8);
    btn_up = 1'b0;
    step(10);

    // Switch synchronizer latency.
    switch = 8'hA5;
    step(1);
    check("sw_sync_one_edge", 32'(sw_sync), 32'd0);
    step(1);
    check("sw_sync_two_edges", 32'(sw_sync), 32'hA5);

    // Bouncing down: 1,0,1 every 2 cycles, then held; pulse 6 edges after last edge.
    t0 = cyc;
    btn_down = 1'b1;
    push_pulse(t0 + 10, M_DOWN, 32'd10, 2'd0);
    step(2); btn_down = 1'b0;
    step(2); btn_down = 1'b1;
    step(8); btn_down = 1'b0;
    step(10);

    // Period saturation both ways, then enter.
    do_reset();
    press(M_DOWN, 32'd12, 2'd0);
    press(M_DOWN, 32'd14, 2'd0);
    press(M_DOWN, 32'd16, 2'd0);
    press(M_DOWN, 32'd16, 2'd0);
    press(M_DOWN, 32'd16, 2'd0);
    press(M_UP, 32'd14, 2'd0);
    press(M_UP, 32'd12, 2'd0);
    press(M_UP, 32'd10, 2'd0);
    press(M_UP, 32'd8, 2'd0);
    press(M_ENTER, 32'd10, 2'd0);

    // Pattern wrap and left+right cancellation.
    do_reset();
    press(M_LEFT, 32'd10, 2'd3);
    press(M_RIGHT, 32'd10, 2'd0);
    press(M_RIGHT, 32'd10, 2'd1);
    press(M_LEFT | M_RIGHT, 32'd10, 2'd1);

    // Tick spacing, then an up press landing at count 6 restarts the count.
    do_reset();
    t0 = cyc;
    tick_en = 1'b1;
    tq.push_back(t0 + 10);
    tq.push_back(t0 + 20);
    tq.push_back(t0 + 30);
    step(30);
    btn_up = 1'b1;
    push_pulse(t0 + 36, M_UP, 32'd8, 2'd0);
    tq.push_back(t0 + 45);
    tq.push_back(t0 + 53);
    tq.push_back(t0 + 61);
    step(8);
    btn_up = 1'b0;
    step(28);
    tick_en = 1'b0;
    check("tick_queue_drained", 32'(tq.size()), 32'd0);

    // Reset mid-debounce with pattern 2; held right is re-debounced from zero.
    do_reset();
    press(M_RIGHT, 32'd10, 2'd1);
    press(M_RIGHT, 32'd10, 2'd2);
    btn_right = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_pattern", 32'(pattern_sel), 32'd0);
    check("midrst_period", period, 32'd10);
    check("midrst_btn_level", 32'(btn_level), 32'd0);
    check("midrst_btn_pulse", 32'(btn_pulse), 32'd0);
    check("midrst_tick", 32'(tick), 32'd0);
    check("midrst_sw_sync", 32'(sw_sync), 32'd0);
    push_pulse(cyc + 6, M_RIGHT, 32'd10, 2'd1);
    step(8);
    btn_right = 1'b0;
    step(12);

    check("pulse_queue_drained", 32'(pq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
